skylark_muldiv: RTL and testbench

//  Parametrised iterative RV32M multiply/divide unit for the Execute stage of the skylark pipeline.

---
 rtl/skylark_muldiv.sv | 213 +++++++++++++++++++++
 tb/tb_skylark_muldiv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skylark_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : skylark_muldiv
//  Description : Iterative RV32M multiply/divide unit for the Execute stage.
//                Shift-add multiplier retiring MUL_BPC bits per cycle and a
//                radix-2 restoring divider working on operand magnitudes.
//                Divide-by-zero and signed overflow bypass the iteration.
//                reset is asynchronous and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module skylark_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int c_MUL_ITER = XLEN / MUL_BPC;
    localparam int c_CNTW     = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    // r_acc: multiply = {partial sum, remaining multiplier};
    //        divide   = {partial remainder, dividend/quotient};
    //        fast path = result in the low half.
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opB;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [c_CNTW-1:0]   r_cnt;
    logic [2:0]          r_funct3;
    logic                r_negQ;     // product / quotient must be negated
    logic                r_negR;     // remainder must be negated
    logic                r_fast;     // result precomputed at accept
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Accept-time decode: signedness, magnitudes and fast-path detection
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_isDiv;
    logic                w_signedA;
    logic                w_signedB;
    logic                w_sA;
    logic                w_sB;
    logic [XLEN-1:0]     w_magA;
    logic [XLEN-1:0]     w_magB;
    logic                w_divZero;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fastRes;
    logic [XLEN-1:0]     w_minInt;

    assign w_minInt  = {1'b1, {(XLEN-1){1'b0}}};
    assign w_accept  = in_valid & (r_state == IDLE) & ~kill;
    assign w_isDiv   = funct3[2];
    // DIV/REM signed on both; MUL/MULH signed on both; MULHSU signed on rs1 only
    assign w_signedA = w_isDiv ? ~funct3[0] : (funct3 != 3'b011);
    assign w_signedB = w_isDiv ? ~funct3[0] : ~funct3[1];
    assign w_sA      = w_signedA & rs1[XLEN-1];
    assign w_sB      = w_signedB & rs2[XLEN-1];
    assign w_magA    = w_sA ? -rs1 : rs1;
    assign w_magB    = w_sB ? -rs2 : rs2;
    assign w_divZero = w_isDiv & (rs2 == '0);
    assign w_ovf     = w_isDiv & ~funct3[0] & (rs1 == w_minInt) & (rs2 == '1);
    assign w_fast    = w_divZero | w_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    assign w_fastRes = w_divZero ? (funct3[1] ? rs1 : '1)
                                 : (funct3[1] ? '0  : rs1);

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand * low MUL_BPC multiplier bits into
    // the upper half, then shift the whole accumulator right.
    // ------------------------------------------------------------------
    logic [XLEN+MUL_BPC-1:0]   w_partial;
    logic [XLEN+MUL_BPC-1:0]   w_sum;
    logic [2*XLEN+MUL_BPC-1:0] w_mulShift;
    logic [2*XLEN-1:0]         w_mulNext;

    assign w_partial  = {{MUL_BPC{1'b0}}, r_opB} * {{XLEN{1'b0}}, r_acc[MUL_BPC-1:0]};
    assign w_sum      = {{MUL_BPC{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_partial;
    assign w_mulShift = {w_sum, r_acc[XLEN-1:0]};
    assign w_mulNext  = w_mulShift[2*XLEN+MUL_BPC-1:MUL_BPC];

    // ------------------------------------------------------------------
    // Divide step: shift in the next dividend bit, subtract if it fits.
    // ------------------------------------------------------------------
    logic [XLEN:0]       w_remSh;
    logic [XLEN:0]       w_trial;
    logic                w_ge;
    logic [2*XLEN-1:0]   w_divNext;

    assign w_remSh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial   = w_remSh - {1'b0, r_opB};
    assign w_ge      = (w_remSh >= {1'b0, r_opB});
    assign w_divNext = w_ge ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                            : {w_remSh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Fix-up: sign correction and half / quotient-remainder select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fixRes;

    assign w_prod = r_negQ ? -r_acc : r_acc;
    assign w_quot = r_negQ ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_negR ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Select the architectural result from the finished datapath
    always_comb begin
        w_fixRes = '0;
        if (r_fast) begin
            w_fixRes = r_acc[XLEN-1:0];
        end else if (!r_funct3[2]) begin
            w_fixRes = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            w_fixRes = r_funct3[1] ? w_rem : w_quot;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; kill overrides every other transition
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_fast)       w_nextState = FIX;
                    else if (w_isDiv) w_nextState = DIV;
                    else              w_nextState = MUL;
                end
            end
            MUL:     if (r_cnt == '0) w_nextState = FIX;
            DIV:     if (r_cnt == '0) w_nextState = FIX;
            FIX:     w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (kill) begin
            w_nextState = IDLE;
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_opB    <= '0;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
            r_fast   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct3 <= funct3;
            r_negQ   <= w_sA ^ w_sB;
            r_negR   <= w_sA;
            r_fast   <= w_fast;
            r_cnt    <= w_isDiv ? c_CNTW'(XLEN - 1) : c_CNTW'(c_MUL_ITER - 1);
            r_opB    <= w_isDiv ? w_magB : w_magA;
            if (w_fast)       r_acc <= {{XLEN{1'b0}}, w_fastRes};
            else if (w_isDiv) r_acc <= {{XLEN{1'b0}}, w_magA};
            else              r_acc <= {{XLEN{1'b0}}, w_magB};
        end else if (!kill) begin
            case (r_state)
                MUL: begin
                    r_acc <= w_mulNext;
                    r_cnt <= r_cnt - c_CNTW'(1);
                end
                DIV: begin
                    r_acc <= w_divNext;
                    r_cnt <= r_cnt - c_CNTW'(1);
                end
                FIX:     r_result <= w_fixRes;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_skylark_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skylark_muldiv
//  Description : Scoreboard bench driving two skylark_muldiv instances
//                (MUL_BPC=1 and MUL_BPC=4) with identical directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_skylark_muldiv;

    localparam int LAT_MUL1 = 33;   // 32/1 iterations + FIX
    localparam int LAT_MUL4 = 9;    // 32/4 iterations + FIX
    localparam int LAT_DIV  = 33;   // 32 iterations + FIX
    localparam int LAT_FAST = 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        longint      tA;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        kill;
    logic        in_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_ready;
    logic        inReady1, outValid1, inReady4, outValid4;
    logic [31:0] result1, result4;

    exp_t        q1[$];
    exp_t        q4[$];
    exp_t        e1, e4;
    logic        ov1Prev, ov4Prev;
    int          nChecks;
    int          nPass;
    bit          sawValid;

    skylark_muldiv #(.XLEN(32), .MUL_BPC(1)) dut1 (
        .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_ready(inReady1),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .out_valid(outValid1),
        .out_ready(out_ready), .result(result1)
    );

    skylark_muldiv #(.XLEN(32), .MUL_BPC(4)) dut4 (
        .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_ready(inReady4),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .out_valid(outValid4),
        .out_ready(out_ready), .result(result4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    endtask

    // Drive one request; the expected response is queued at the accept edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int l1, input int l4, input bit push);
        exp_t ent;
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = f;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        ent.res = exp;
        ent.tA  = longint'($time);
        if (push) begin
            ent.lat = l1;
            q1.push_back(ent);
            ent.lat = l4;
            q4.push_back(ent);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (inReady1 && inReady4) done = 1'b1;
        end
        if (!done) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    // Monitor for the MUL_BPC=1 instance
    always @(negedge clk) begin
        if (outValid1 && !ov1Prev) begin
            if (q1.size() == 0) begin
                check("d1_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("d1_result", 64'(result1), 64'(e1.res));
                check("d1_latency", 64'((longint'($time) - 5 - e1.tA) / 10), 64'(e1.lat));
            end
        end
        ov1Prev <= outValid1;
    end

    // Monitor for the MUL_BPC=4 instance
    always @(negedge clk) begin
        if (outValid4 && !ov4Prev) begin
            if (q4.size() == 0) begin
                check("d4_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e4 = q4.pop_front();
                check("d4_result", 64'(result4), 64'(e4.res));
                check("d4_latency", 64'((longint'($time) - 5 - e4.tA) / 10), 64'(e4.lat));
            end
        end
        ov4Prev <= outValid4;
    end

    initial begin
        nChecks   = 0;
        nPass     = 0;
        ov1Prev   = 1'b0;
        ov4Prev   = 1'b0;
        reset     = 1'b0;
        kill      = 1'b0;
        in_valid  = 1'b0;
        funct3    = 3'd0;
        rs1       = '0;
        rs2       = '0;
        out_ready = 1'b1;

        #2;
        check("rst_d1_out_valid", 64'(outValid1), 64'd0);
        check("rst_d4_out_valid", 64'(outValid4), 64'd0);
        check("rst_d1_result",    64'(result1),   64'd0);
        check("rst_d4_result",    64'(result4),   64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_d1_in_ready", 64'(inReady1), 64'd1);
        check("rst_d4_in_ready", 64'(inReady4), 64'd1);

        // Multiplies
        issue(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b000, 32'h12345678, 32'h10,       32'h23456780, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();
        issue(3'b011, 32'h80000000, 32'd2,        32'h00000001, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();

        // Divides
        issue(3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b101, 32'd20,       32'd3,        32'd6,        LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b111, 32'd20,       32'd3,        32'd2,        LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_DIV, LAT_DIV, 1'b1); waitIdle();
        issue(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_DIV, LAT_DIV, 1'b1); waitIdle();

        // Fast paths
        issue(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_FAST, LAT_FAST, 1'b1); waitIdle();
        issue(3'b111, 32'd5,        32'd0,        32'd5,        LAT_FAST, LAT_FAST, 1'b1); waitIdle();
        issue(3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, LAT_FAST, LAT_FAST, 1'b1); waitIdle();
        issue(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_FAST, LAT_FAST, 1'b1); waitIdle();
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST, LAT_FAST, 1'b1); waitIdle();
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_FAST, LAT_FAST, 1'b1); waitIdle();

        // Back-pressure: hold the result for 10 cycles
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd4, 32'd12, LAT_MUL1, LAT_MUL4, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (outValid1 && outValid4) seen = 1'b1;
            end
            check("bp_both_valid", 64'(seen), 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_d1_result",    64'(result1),   64'd12);
            check("bp_d4_result",    64'(result4),   64'd12);
            check("bp_d1_out_valid", 64'(outValid1), 64'd1);
            check("bp_d4_out_valid", 64'(outValid4), 64'd1);
            check("bp_d1_in_ready",  64'(inReady1),  64'd0);
            check("bp_d4_in_ready",  64'(inReady4),  64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_d1_idle",      64'(inReady1),  64'd1);
        check("bp_d4_idle",      64'(inReady4),  64'd1);
        check("bp_d1_valid_low", 64'(outValid1), 64'd0);
        check("bp_d4_valid_low", 64'(outValid4), 64'd0);

        // Flush: kill sampled at edge T+6 of a DIV
        issue(3'b100, 32'd100, 32'd7, 32'd0, LAT_DIV, LAT_DIV, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("kill_d1_busy", 64'(inReady1), 64'd0);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_d1_idle",      64'(inReady1),  64'd1);
        check("kill_d4_idle",      64'(inReady4),  64'd1);
        check("kill_d1_valid_low", 64'(outValid1), 64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid1 || outValid4) sawValid = 1'b1;
        end
        check("kill_no_valid", 64'(sawValid), 64'd0);

        // kill together with in_valid in IDLE: request refused
        @(negedge clk);
        in_valid = 1'b1;
        kill     = 1'b1;
        funct3   = 3'b000;
        rs1      = 32'd9;
        rs2      = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("killreq_d1_in_ready", 64'(inReady1), 64'd1);
        check("killreq_d4_in_ready", 64'(inReady4), 64'd1);

        issue(3'b000, 32'd3, 32'd4, 32'd12, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();

        // Reset asserted mid-multiply
        issue(3'b000, 32'd5, 32'd6, 32'd30, LAT_MUL1, LAT_MUL4, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_d1_out_valid", 64'(outValid1), 64'd0);
        check("midrst_d4_out_valid", 64'(outValid4), 64'd0);
        check("midrst_d1_result",    64'(result1),   64'd0);
        check("midrst_d4_result",    64'(result4),   64'd0);
        check("midrst_d1_in_ready",  64'(inReady1),  64'd1);
        check("midrst_d4_in_ready",  64'(inReady4),  64'd1);
        @(negedge clk);
        reset = 1'b1;

        issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL1, LAT_MUL4, 1'b1); waitIdle();

        check("d1_queue_drained", 64'(q1.size()), 64'd0);
        check("d4_queue_drained", 64'(q4.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
